cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Per-hart run/stop controller; the parametrised successor of the single-bit CPU run-state flag.
- Sits between the control/debug command decoder and the CPU pipelines. Drives one stall line per hart.
- Adds single-step by retired-instruction count, a shared PC breakpoint, sticky halt-cause status and a saturating per-hart run-cycle counter.

Parameters:
- NUM_HART, 2, number of independently controlled harts (1..8)
- PC_W, 30, width of retire_pc / brk_adr (word address)
- STEP_W, 16, width of the step count
- CNT_W, 32, width of each run-cycle counter

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- init_cpu_start  input  NUM_HART  per-hart run state loaded at reset
- cpu_start  input  NUM_HART  pulse: enter RUN
- quit_cmd  input  NUM_HART  pulse: enter STOP
- step_cmd  input  NUM_HART  pulse: enter STEP with step_num
- step_num  input  STEP_W  instructions to retire for step_cmd (shared)
- brk_en  input  1  breakpoint enable
- brk_adr  input  PC_W  breakpoint address
- retire_valid  input  NUM_HART  per-hart instruction retired this cycle
- retire_pc  input  NUM_HART*PC_W  retired PC, hart h at [h*PC_W +: PC_W]
- cnt_clr  input  NUM_HART  clear run-cycle counter
- stall  output  NUM_HART  1 = hart stopped
- step_done  output  NUM_HART  1-cycle pulse: step sequence completed
- brk_hit  output  NUM_HART  1-cycle pulse: breakpoint stop
- halt_cause  output  2*NUM_HART  sticky per hart: 00 none, 01 quit, 10 step, 11 brk
- run_cnt  output  NUM_HART*CNT_W  per-hart run-cycle count

Behaviour:
- Each hart has an independent FSM with states STOP, RUN and STEP. There is no cross-hart interaction except the shared step_num and the breakpoint inputs.
- Reset: state is RUN if init_cpu_start[h] is 1, otherwise STOP. At reset:
  - step counter = 0
  - step_done, brk_hit = 0
  - halt_cause = 00
  - run_cnt = 0
  - stall[h] = ~init_cpu_start[h] from the first post-reset cycle
- stall[h] = (state == STOP). It is decoded from the state register with no extra latency.
- Priority per hart each cycle, highest first: rst, quit_cmd, breakpoint hit, step completion, step_cmd, cpu_start.
- quit_cmd (any state) -> STOP next cycle. halt_cause = 01 if the state was RUN/STEP; it is unchanged if already STOP.
- Breakpoint hit condition: brk_en && retire_valid[h] && retire_pc[h] == brk_adr, while in RUN or STEP.
  - Effect: -> STOP, brk_hit[h] pulses for 1 cycle (registered, same edge as the state change), halt_cause = 11.
  - The matching instruction has already retired; it is not re-executed.
  - Retires while in STOP are ignored.
- step_cmd accepted only in STOP: -> STEP, counter loaded with step_num. step_num == 0 is treated as 1. step_cmd in RUN/STEP is ignored.
- In STEP, each retire_valid[h] decrements the counter.
  - A retire while counter == 1 -> STOP next edge, step_done[h] pulses 1 cycle, halt_cause = 10.
  - If the same retire also hits the breakpoint, breakpoint wins: brk_hit pulses, step_done does not pulse, halt_cause = 11.
- cpu_start accepted in STOP or STEP -> RUN. It clears halt_cause to 00 and aborts any step in progress (counter cleared). Ignored in RUN.
- Simultaneous step_cmd and cpu_start in STOP -> STEP (step_cmd wins).
- run_cnt[h]:
  - Increments by 1 on every cycle where stall[h] == 0.
  - Saturates at all-ones (no wrap).
  - cnt_clr[h] sets it to 0 and has priority over increment. A clear-and-run cycle leaves 0.
- Reset asserted mid-step or mid-run: all per-hart state returns to the reset values in the same cycle. Pending pulses are dropped.
- Outputs step_done and brk_hit are never both 1 for a hart in the same cycle.

Test Plan:
1. Reset with init_cpu_start=2'b01, hold 3 cycles -> stall=2'b10. run_cnt[0]=2, run_cnt[1]=0 on the 3rd post-reset cycle. halt_cause=0.
2. Hart1 in STOP, step_num=3, step_cmd[1] pulse, then retire_valid[1] on cycles 2, 4 and 5 -> stall[1]=0 until the edge after the 3rd retire, then 1. step_done[1] pulses exactly once. halt_cause[3:2]=10.
3. Hart0 RUN, brk_en=1, brk_adr=30'h40, retires at PC 3C then 40 -> stall[0]=1 the cycle after the PC 40 retire. brk_hit[0] is a 1-cycle pulse. halt_cause[1:0]=11. A later cpu_start[0] clears halt_cause to 00 and resumes.
4. Hart1 in STEP with counter=1, final retire at PC==brk_adr with brk_en=1 -> brk_hit[1]=1, step_done[1]=0, halt_cause=11. Same cycle with quit_cmd[1]=1 -> halt_cause=01, no pulses.
5. CNT_W=4: run 20 cycles -> run_cnt=4'hF holds. cnt_clr pulse while running -> 0 on that edge, then 1 next cycle.
6. Assert rst mid-step (counter=5) with init_cpu_start=0 -> stall=1, no step_done. A subsequent retire_valid has no effect.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: per-hart run/stop controller.
//
// Each hart owns an independent STOP/RUN/STEP state machine that drives its
// stall line. Single-step retires a programmable number of instructions, a
// shared PC breakpoint stops any running or stepping hart, the reason for the
// last stop is kept as a sticky halt cause, and a saturating counter tracks
// the cycles each hart spent unstalled.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   init_cpu_start  per-hart run state loaded while rst is high
//   cpu_start       pulse per hart: enter RUN (from STOP or STEP)
//   quit_cmd        pulse per hart: enter STOP
//   step_cmd        pulse per hart: enter STEP with step_num (from STOP)
//   step_num        shared step count, 0 behaves as 1
//   brk_en, brk_adr shared breakpoint enable / word address
//   retire_valid    per-hart instruction retired this cycle
//   retire_pc       per-hart retired PC, hart h at [h*PC_W +: PC_W]
//   cnt_clr         per-hart run-cycle counter clear
//   stall           1 = hart stopped
//   step_done       1-cycle pulse: step sequence completed
//   brk_hit         1-cycle pulse: breakpoint stop
//   halt_cause      2 bits per hart: 00 none, 01 quit, 10 step, 11 brk
//   run_cnt         per-hart saturating run-cycle count, CNT_W bits each
//
// state | meaning
// ------+-----------------------------------------------------------
// STOP  | hart stalled, waits for cpu_start or step_cmd
// RUN   | hart free running until quit or breakpoint
// STEP  | hart runs until step counter expires, quit or breakpoint

module cpu_run_ctrl #(
  parameter int NUM_HART = 2,
  parameter int PC_W     = 30,
  parameter int STEP_W   = 16,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_HART-1:0]        init_cpu_start,
  input  logic [NUM_HART-1:0]        cpu_start,
  input  logic [NUM_HART-1:0]        quit_cmd,
  input  logic [NUM_HART-1:0]        step_cmd,
  input  logic [STEP_W-1:0]          step_num,
  input  logic                       brk_en,
  input  logic [PC_W-1:0]            brk_adr,
  input  logic [NUM_HART-1:0]        retire_valid,
  input  logic [NUM_HART*PC_W-1:0]   retire_pc,
  input  logic [NUM_HART-1:0]        cnt_clr,
  output logic [NUM_HART-1:0]        stall,
  output logic [NUM_HART-1:0]        step_done,
  output logic [NUM_HART-1:0]        brk_hit,
  output logic [2*NUM_HART-1:0]      halt_cause,
  output logic [NUM_HART*CNT_W-1:0]  run_cnt
);

  localparam logic [1:0] ST_STOP = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_QUIT = 2'b01;
  localparam logic [1:0] CAUSE_STEP = 2'b10;
  localparam logic [1:0] CAUSE_BRK  = 2'b11;

  // Zero step count is treated as a single step.
  logic [STEP_W-1:0] step_load;
  assign step_load = (step_num == '0) ? STEP_W'(1) : step_num;

  for (genvar g = 0; g < NUM_HART; g++) begin : g_hart
    logic [1:0]        state_q, state_d;
    logic [STEP_W-1:0] scnt_q, scnt_d;
    logic [1:0]        cause_q, cause_d;
    logic              done_q, done_d;
    logic              brk_q, brk_d;
    logic [CNT_W-1:0]  rcnt_q, rcnt_d;
    logic              active;
    logic              brk_match;
    logic              step_last;

    assign active    = (state_q != ST_STOP);
    // Retires while stopped never count as a breakpoint.
    assign brk_match = active && brk_en && retire_valid[g] &&
                       (retire_pc[g*PC_W +: PC_W] == brk_adr);
    assign step_last = (state_q == ST_STEP) && retire_valid[g] &&
                       (scnt_q == STEP_W'(1));

    always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      cause_d = cause_q;
      done_d  = 1'b0;
      brk_d   = 1'b0;
      if (quit_cmd[g]) begin
        state_d = ST_STOP;
        scnt_d  = '0;
        if (active) cause_d = CAUSE_QUIT;
      end else if (brk_match) begin
        // Breakpoint outranks a coincident final step retire.
        state_d = ST_STOP;
        scnt_d  = '0;
        cause_d = CAUSE_BRK;
        brk_d   = 1'b1;
      end else if (step_last) begin
        state_d = ST_STOP;
        scnt_d  = '0;
        cause_d = CAUSE_STEP;
        done_d  = 1'b1;
      end else if (step_cmd[g] && (state_q == ST_STOP)) begin
        state_d = ST_STEP;
        scnt_d  = step_load;
      end else if (cpu_start[g] && (state_q != ST_RUN)) begin
        state_d = ST_RUN;
        scnt_d  = '0;
        cause_d = CAUSE_NONE;
      end else if ((state_q == ST_STEP) && retire_valid[g]) begin
        scnt_d  = scnt_q - STEP_W'(1);
      end
    end

    always_comb begin
      rcnt_d = rcnt_q;
      if (cnt_clr[g]) rcnt_d = '0;
      else if (active && (rcnt_q != '1)) rcnt_d = rcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= init_cpu_start[g] ? ST_RUN : ST_STOP;
        scnt_q  <= '0;
        cause_q <= CAUSE_NONE;
        done_q  <= 1'b0;
        brk_q   <= 1'b0;
        rcnt_q  <= '0;
      end else begin
        state_q <= state_d;
        scnt_q  <= scnt_d;
        cause_q <= cause_d;
        done_q  <= done_d;
        brk_q   <= brk_d;
        rcnt_q  <= rcnt_d;
      end
    end

    assign stall[g]                   = (state_q == ST_STOP);
    assign step_done[g]               = done_q;
    assign brk_hit[g]                 = brk_q;
    assign halt_cause[2*g +: 2]       = cause_q;
    assign run_cnt[g*CNT_W +: CNT_W]  = rcnt_q;
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
module tb_cpu_run_ctrl;
  localparam int NH    = 2;
  localparam int PC_W  = 30;
  localparam int STEPW = 16;
  localparam int CNT_W = 4;

  localparam logic [1:0] K_STEP = 2'd1;
  localparam logic [1:0] K_BRK  = 2'd2;

  typedef struct packed {
    logic [2:0] hart;
    logic [1:0] kind;
    logic [1:0] cause;
  } ev_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NH-1:0]         init_cpu_start, cpu_start, quit_cmd, step_cmd;
  logic [STEPW-1:0]      step_num;
  logic                  brk_en;
  logic [PC_W-1:0]       brk_adr;
  logic [NH-1:0]         retire_valid;
  logic [PC_W-1:0]       pc0, pc1;
  logic [NH*PC_W-1:0]    retire_pc;
  logic [NH-1:0]         cnt_clr;
  logic [NH-1:0]         stall, step_done, brk_hit;
  logic [2*NH-1:0]       halt_cause;
  logic [NH*CNT_W-1:0]   run_cnt;

  int total = 0;
  int bad   = 0;
  ev_t exp_q[$];

  assign retire_pc = {pc1, pc0};

  cpu_run_ctrl #(.NUM_HART(NH), .PC_W(PC_W), .STEP_W(STEPW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .init_cpu_start(init_cpu_start), .cpu_start(cpu_start),
    .quit_cmd(quit_cmd), .step_cmd(step_cmd), .step_num(step_num), .brk_en(brk_en),
    .brk_adr(brk_adr), .retire_valid(retire_valid), .retire_pc(retire_pc),
    .cnt_clr(cnt_clr), .stall(stall), .step_done(step_done), .brk_hit(brk_hit),
    .halt_cause(halt_cause), .run_cnt(run_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input int h, input logic [1:0] kind, input logic [1:0] cause);
    ev_t e;
    e.hart  = 3'(h);
    e.kind  = kind;
    e.cause = cause;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every pulse on step_done/brk_hit must match the next
  // queued expectation, including the halt cause latched on the same edge.
  initial begin
    ev_t got, want;
    forever begin
      @(negedge clk);
      for (int h = 0; h < NH; h++) begin
        if (step_done[h] || brk_hit[h]) begin
          got.hart  = 3'(h);
          got.kind  = {brk_hit[h], step_done[h]};
          got.cause = halt_cause[2*h +: 2];
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse: got hart=%0d kind=%0d cause=%0b, none expected",
                     got.hart, got.kind, got.cause);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              bad++;
              $display("FAIL pulse_event: got hart=%0d kind=%0d cause=%0b expected hart=%0d kind=%0d cause=%0b",
                       got.hart, got.kind, got.cause, want.hart, want.kind, want.cause);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; init_cpu_start = 2'b01; cpu_start = '0; quit_cmd = '0; step_cmd = '0;
    step_num = '0; brk_en = 1'b0; brk_adr = '0; retire_valid = '0; pc0 = '0; pc1 = '0;
    cnt_clr = '0;

    // 1: reset with hart0 running, hart1 stopped
    repeat (3) tick();
    chk("rst_stall", 32'(stall), 32'h2);
    chk("rst_cnt", 32'(run_cnt), 32'h0);
    chk("rst_cause", 32'(halt_cause), 32'h0);
    rst = 1'b0;
    tick();
    tick();
    chk("t1_stall", 32'(stall), 32'h2);
    chk("t1_cnt0", 32'(run_cnt[3:0]), 32'd2);
    chk("t1_cnt1", 32'(run_cnt[7:4]), 32'd0);
    chk("t1_cause", 32'(halt_cause), 32'h0);

    // 2: hart1 steps three retires
    step_num = 16'd3; step_cmd = 2'b10;
    tick();
    step_cmd = '0;
    chk("t2_stall_step", 32'(stall[1]), 32'd0);
    tick();
    retire_valid = 2'b10; pc1 = 30'h100;
    tick();
    retire_valid = '0;
    chk("t2_stall_r1", 32'(stall[1]), 32'd0);
    tick();
    retire_valid = 2'b10; pc1 = 30'h104;
    tick();
    chk("t2_stall_r2", 32'(stall[1]), 32'd0);
    pc1 = 30'h108;
    expect_ev(1, K_STEP, 2'b10);
    tick();
    retire_valid = '0;
    chk("t2_stall_done", 32'(stall[1]), 32'd1);
    chk("t2_cause", 32'(halt_cause[3:2]), 32'b10);
    tick();

    // 3: breakpoint on hart0; hart1 retire at the same PC while stopped is ignored
    brk_en = 1'b1; brk_adr = 30'h40;
    retire_valid = 2'b01; pc0 = 30'h3C;
    tick();
    chk("t3_no_brk", 32'(stall[0]), 32'd0);
    retire_valid = 2'b11; pc0 = 30'h40; pc1 = 30'h40;
    expect_ev(0, K_BRK, 2'b11);
    tick();
    retire_valid = '0;
    chk("t3_stall", 32'(stall), 32'h3);
    chk("t3_cause", 32'(halt_cause), 32'b1011);
    tick();
    cpu_start = 2'b01;
    tick();
    cpu_start = '0;
    chk("t3_resume_cause", 32'(halt_cause[1:0]), 32'd0);
    chk("t3_resume_stall", 32'(stall[0]), 32'd0);

    // 4a: step_num 0 acts as 1; step_cmd beats a simultaneous cpu_start
    step_num = '0; step_cmd = 2'b10; cpu_start = 2'b10;
    tick();
    step_cmd = '0; cpu_start = '0;
    retire_valid = 2'b10; pc1 = 30'h10;
    expect_ev(1, K_STEP, 2'b10);
    tick();
    retire_valid = '0;
    chk("t4a_stall", 32'(stall[1]), 32'd1);
    chk("t4a_cause", 32'(halt_cause[3:2]), 32'b10);
    // 4b: last step retire hits the breakpoint
    step_cmd = 2'b10;
    tick();
    step_cmd = '0;
    retire_valid = 2'b10; pc1 = 30'h40;
    expect_ev(1, K_BRK, 2'b11);
    tick();
    retire_valid = '0;
    chk("t4b_stall", 32'(stall[1]), 32'd1);
    chk("t4b_cause", 32'(halt_cause[3:2]), 32'b11);
    // 4c: quit in the same cycle wins, no pulses
    step_num = 16'd1; step_cmd = 2'b10;
    tick();
    step_cmd = '0;
    retire_valid = 2'b10; pc1 = 30'h40; quit_cmd = 2'b10;
    tick();
    retire_valid = '0; quit_cmd = '0;
    chk("t4c_stall", 32'(stall[1]), 32'd1);
    chk("t4c_cause", 32'(halt_cause[3:2]), 32'b01);
    brk_en = 1'b0;

    // 5: saturating run counter
    cnt_clr = 2'b11;
    tick();
    cnt_clr = '0;
    chk("t5_clr0", 32'(run_cnt[3:0]), 32'd0);
    chk("t5_clr1", 32'(run_cnt[7:4]), 32'd0);
    tick();
    chk("t5_inc", 32'(run_cnt[3:0]), 32'd1);
    chk("t5_stopped", 32'(run_cnt[7:4]), 32'd0);
    repeat (20) tick();
    chk("t5_sat", 32'(run_cnt[3:0]), 32'hF);
    tick();
    chk("t5_sat_hold", 32'(run_cnt[3:0]), 32'hF);
    cnt_clr = 2'b01;
    tick();
    cnt_clr = '0;
    chk("t5_clr_run", 32'(run_cnt[3:0]), 32'd0);
    tick();
    chk("t5_after_clr", 32'(run_cnt[3:0]), 32'd1);

    // 6: reset in the middle of a 5-step sequence
    step_num = 16'd5; step_cmd = 2'b10;
    tick();
    step_cmd = '0;
    chk("t6_in_step", 32'(stall[1]), 32'd0);
    init_cpu_start = 2'b00; rst = 1'b1; retire_valid = 2'b11; pc1 = 30'h20;
    tick();
    rst = 1'b0;
    chk("t6_rst_stall", 32'(stall), 32'h3);
    chk("t6_rst_cause", 32'(halt_cause), 32'h0);
    repeat (6) tick();
    retire_valid = '0;
    chk("t6_stall_hold", 32'(stall), 32'h3);
    chk("t6_cnt", 32'(run_cnt), 32'h0);
    tick();
    tick();

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
